// File: rtl/clock_enable_sequencer.sv
// Clock/reset supervisor: after PLL lock, releases per-subsystem active-low resets in a
// fixed order and drives one run-time-programmable clock-enable stream per channel.
`timescale 1ns/1ps
module clock_enable_sequencer #(
  parameter int NCH  = 4,
  parameter int DW   = 8,
  parameter int HOLD = 16,
  parameter int GAP  = 4
) (
  input  logic              clock,
  input  logic              locked,
  input  logic [NCH*DW-1:0] div,
  input  logic [NCH-1:0]    div_load,
  output logic [NCH-1:0]    ce,
  output logic [NCH-1:0]    rst_n,
  output logic              ready
);

  localparam int MAXHG = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW    = $clog2(MAXHG) + 1;
  localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {S_HOLD, S_STAGE, S_RUN} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_seq;
  logic [IW-1:0]   r_idx;
  logic [NCH-1:0]  r_rst_n;
  logic            r_ready;
  logic [NCH-1:0]  r_ce;
  logic [NCH-1:0]  r_pend;
  logic [DW-1:0]   r_cnt [NCH];
  logic [DW-1:0]   r_dv  [NCH];

  // Release sequencer: HOLD edges after lock, then one channel every GAP edges.
  always_ff @(posedge clock or negedge locked) begin
    if (!locked) begin
      r_state <= S_HOLD;
      r_seq   <= '0;
      r_idx   <= '0;
      r_rst_n <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (r_seq == CW'(HOLD - 1)) begin
            r_seq      <= '0;
            r_rst_n[0] <= 1'b1;
            r_idx      <= IW'(1);
            if (NCH == 1) begin
              r_ready <= 1'b1;
              r_state <= S_RUN;
            end else begin
              r_state <= S_STAGE;
            end
          end else begin
            r_seq <= r_seq + CW'(1);
          end
        end
        S_STAGE: begin
          if (r_seq == CW'(GAP - 1)) begin
            r_seq          <= '0;
            r_rst_n[r_idx] <= 1'b1;
            r_idx          <= r_idx + IW'(1);
            if (r_idx == IW'(NCH - 1)) begin
              r_ready <= 1'b1;
              r_state <= S_RUN;
            end
          end else begin
            r_seq <= r_seq + CW'(1);
          end
        end
        S_RUN:   r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase
    end
  end

  // Enable dividers: a new divisor is only adopted on a wrap edge so no period is cut short.
  always_ff @(posedge clock or negedge locked) begin
    if (!locked) begin
      for (int k = 0; k < NCH; k++) begin
        r_cnt[k] <= '0;
        r_dv[k]  <= '0;
      end
      r_ce   <= '0;
      r_pend <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (!r_rst_n[k]) begin
          r_cnt[k]  <= '0;
          r_dv[k]   <= div[k*DW +: DW];
          r_ce[k]   <= 1'b0;
          r_pend[k] <= 1'b0;
        end else if (r_cnt[k] == r_dv[k]) begin
          r_cnt[k] <= '0;
          r_ce[k]  <= 1'b1;
          if (r_pend[k] | div_load[k]) begin
            r_dv[k]   <= div[k*DW +: DW];
            r_pend[k] <= 1'b0;
          end
        end else begin
          r_cnt[k]  <= r_cnt[k] + DW'(1);
          r_ce[k]   <= 1'b0;
          r_pend[k] <= r_pend[k] | div_load[k];
        end
      end
    end
  end

  assign ce    = r_ce;
  assign rst_n = r_rst_n;
  assign ready = r_ready;

endmodule

// File: tb/tb_clock_enable_sequencer.sv
// Bench for clock_enable_sequencer: per-edge expectations queued from a behavioural model,
// plus directed timing/period checks against fixed values.
`timescale 1ns/1ps
module tb_clock_enable_sequencer;

  localparam int NCH  = 4;
  localparam int DW   = 8;
  localparam int HOLD = 16;
  localparam int GAP  = 4;

  logic              clock = 1'b0;
  logic              locked = 1'b0;
  logic [NCH*DW-1:0] div = '0;
  logic [NCH-1:0]    div_load = '0;
  logic [NCH-1:0]    ce;
  logic [NCH-1:0]    rst_n;
  logic              ready;

  clock_enable_sequencer #(.NCH(NCH), .DW(DW), .HOLD(HOLD), .GAP(GAP)) dut (
    .clock(clock), .locked(locked), .div(div), .div_load(div_load),
    .ce(ce), .rst_n(rst_n), .ready(ready)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NCH-1:0] ce;
    logic [NCH-1:0] rst;
    logic           ready;
  } exp_t;

  exp_t q[$];
  int n_pass = 0;
  int n_chk  = 0;
  int edge_n = 0;

  int             m_n;
  int             m_cnt [NCH];
  int             m_dv  [NCH];
  logic [NCH-1:0] m_pend, m_ce, m_rst;
  logic           m_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic push_exp();
    exp_t e;
    e.ce = m_ce; e.rst = m_rst; e.ready = m_ready;
    q.push_back(e);
  endtask

  task automatic model_reset();
    m_n = 0; m_pend = '0; m_ce = '0; m_rst = '0; m_ready = 1'b0;
    for (int k = 0; k < NCH; k++) begin m_cnt[k] = 0; m_dv[k] = 0; end
    push_exp();
  endtask

  // Channels see the release state from before this edge; releases follow lock-relative timing.
  task automatic model_edge();
    for (int k = 0; k < NCH; k++) begin
      int d;
      d = int'(div[k*DW +: DW]);
      if (!m_rst[k]) begin
        m_cnt[k] = 0; m_ce[k] = 1'b0; m_pend[k] = 1'b0; m_dv[k] = d;
      end else if (m_cnt[k] == m_dv[k]) begin
        m_cnt[k] = 0; m_ce[k] = 1'b1;
        if (m_pend[k] || div_load[k]) begin m_dv[k] = d; m_pend[k] = 1'b0; end
      end else begin
        m_cnt[k]++; m_ce[k] = 1'b0;
        if (div_load[k]) m_pend[k] = 1'b1;
      end
    end
    m_n++;
    for (int k = 0; k < NCH; k++) m_rst[k] = (m_n >= HOLD + k*GAP);
    m_ready = (m_n >= HOLD + (NCH-1)*GAP);
    push_exp();
  endtask

  task automatic compare_out();
    exp_t e;
    if (q.size() == 0) begin
      chk("queue_empty", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk("ce", 32'(ce), 32'(e.ce));
      chk("rst_n", 32'(rst_n), 32'(e.rst));
      chk("ready", 32'(ready), 32'(e.ready));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    edge_n++;
    compare_out();
  endtask

  task automatic set_div(input int ch, input int v);
    div[ch*DW +: DW] = DW'(v);
  endtask

  // Interval in edges between the next two pulses of channel ch (-1 on timeout).
  task automatic measure(input int ch, output int per);
    int t;
    per = -1;
    t = 0;
    do begin step(); t++; end while (!ce[ch] && t < 600);
    if (ce[ch]) begin
      t = 0;
      do begin step(); t++; end while (!ce[ch] && t < 600);
      if (ce[ch]) per = t;
    end
  endtask

  task automatic async_drop();
    locked = 1'b0;
    #1;
    model_reset();
    compare_out();
    #1;
    locked = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rst [NCH];
    int first_rdy, first_ce0, first_ce1, per;

    set_div(0, 3); set_div(1, 0); set_div(2, 255); set_div(3, 5);
    #1;
    model_reset();
    compare_out();
    #1;
    locked = 1'b1;
    edge_n = 0;

    for (int k = 0; k < NCH; k++) first_rst[k] = -1;
    first_rdy = -1; first_ce0 = -1; first_ce1 = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      for (int k = 0; k < NCH; k++)
        if (rst_n[k] && first_rst[k] < 0) first_rst[k] = edge_n;
      if (ready && first_rdy < 0) first_rdy = edge_n;
      if (ce[0] && first_ce0 < 0) first_ce0 = edge_n;
      if (ce[1] && first_ce1 < 0) first_ce1 = edge_n;
    end
    chk("rst0_edge", first_rst[0], 16);
    chk("rst1_edge", first_rst[1], 20);
    chk("rst2_edge", first_rst[2], 24);
    chk("rst3_edge", first_rst[3], 28);
    chk("ready_edge", first_rdy, 28);
    chk("ce0_first", first_ce0, 20);
    chk("ce1_first", first_ce1, 21);

    measure(0, per); chk("ch0_period4", per, 4);
    measure(3, per); chk("ch3_period6", per, 6);
    measure(2, per); chk("ch2_period256", per, 256);

    // Mid-period reload: old period finishes, then period 2.
    measure(0, per);
    step();
    set_div(0, 1); div_load[0] = 1'b1;
    step();
    div_load[0] = 1'b0;
    measure(0, per); chk("midload_period2", per, 2);

    set_div(0, 6);
    measure(0, per); chk("noload_period2", per, 2);
    step();
    set_div(0, 2); div_load[0] = 1'b1;
    step();
    div_load[0] = 1'b0;
    chk("wrapload_ce0", 32'(ce[0]), 32'd1);
    measure(0, per); chk("wrapload_period3", per, 3);

    // Lock lost while releases are still in progress.
    async_drop();
    repeat (20) step();
    chk("stage_rst_n", 32'(rst_n), 32'h3);
    async_drop();
    chk("drop_ce", 32'(ce), 32'h0);
    first_rst[0] = -1;
    repeat (30) begin
      step();
      if (rst_n[0] && first_rst[0] < 0) first_rst[0] = edge_n;
    end
    chk("restart_rst0", first_rst[0], 16);

    for (int i = 0; i < 10000; i++) begin
      for (int k = 0; k < NCH; k++) begin
        div_load[k] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 3) == 0)
          set_div(k, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                                  : int'($urandom_range(0, 5)));
      end
      if (i % 2500 == 1234) async_drop();
      step();
    end
    div_load = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
